// File: rtl/clk_drv_sequencer.sv
// Clock driver enable sequencer: waits for PLL lock, then staggers
// channel enables on/off to limit the supply current step.
module clk_drv_sequencer #(
  parameter int N_DRV     = 4,
  parameter int STAGGER_W = 8,
  parameter int LOCK_CYC  = 16
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pll_lock,
  input  logic [N_DRV-1:0]     chan_mask,
  input  logic [STAGGER_W-1:0] stagger,
  output logic [N_DRV-1:0]     drv_en,
  output logic                 busy,
  output logic                 ready,
  output logic                 lock_err
);

  localparam int PW = (N_DRV > 1) ? $clog2(N_DRV) : 1;
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam logic [PW-1:0] LAST = PW'(N_DRV - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOCK, ENABLE, RUN, DISABLE
  } state_t;

  state_t               state, state_n;
  logic [N_DRV-1:0]     mask_q, mask_n;
  logic [STAGGER_W-1:0] stag_q, stag_n;
  logic [STAGGER_W-1:0] gap, gap_n;
  logic [LW-1:0]        lock_cnt, cnt_n;
  logic [PW-1:0]        ptr, ptr_n;
  logic [N_DRV-1:0]     en_n;
  logic                 err_n;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state    <= IDLE;
      mask_q   <= '0;
      stag_q   <= '0;
      gap      <= '0;
      lock_cnt <= '0;
      ptr      <= '0;
      drv_en   <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_n;
      mask_q   <= mask_n;
      stag_q   <= stag_n;
      gap      <= gap_n;
      lock_cnt <= cnt_n;
      ptr      <= ptr_n;
      drv_en   <= en_n;
      busy     <= (state_n == WAIT_LOCK) ||
                  (state_n == ENABLE) ||
                  (state_n == DISABLE);
      ready    <= (state_n == RUN);
      lock_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    stag_n  = stag_q;
    gap_n   = gap;
    cnt_n   = lock_cnt;
    ptr_n   = ptr;
    en_n    = drv_en;
    err_n   = lock_err;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = WAIT_LOCK;
          mask_n  = chan_mask;
          stag_n  = stagger;
          err_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!pll_lock) begin
          cnt_n = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_n = ENABLE;
          cnt_n   = '0;
          ptr_n   = '0;
          gap_n   = '0;
        end else begin
          cnt_n = lock_cnt + 1'b1;
        end
      end
      ENABLE: begin
        if (!pll_lock) begin
          state_n = IDLE;
          en_n    = '0;
          err_n   = 1'b1;
          gap_n   = '0;
          ptr_n   = '0;
        end else if (stop) begin
          state_n = DISABLE;
          ptr_n   = LAST;
          gap_n   = '0;
        end else if (gap != '0) begin
          gap_n = gap - 1'b1;
        end else begin
          if (mask_q[ptr]) begin
            en_n[ptr] = 1'b1;
            gap_n     = stag_q;
          end
          // last index goes straight to RUN, no trailing gap
          if (ptr == LAST) begin
            state_n = RUN;
            gap_n   = '0;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
      end
      RUN: begin
        if (!pll_lock) begin
          state_n = IDLE;
          en_n    = '0;
          err_n   = 1'b1;
          ptr_n   = '0;
        end else if (stop) begin
          state_n = DISABLE;
          ptr_n   = LAST;
          gap_n   = '0;
        end
      end
      DISABLE: begin
        if (gap != '0) begin
          gap_n = gap - 1'b1;
        end else begin
          if (mask_q[ptr]) begin
            en_n[ptr] = 1'b0;
            gap_n     = stag_q;
          end
          if (ptr == '0) begin
            state_n = IDLE;
            en_n    = '0;
            gap_n   = '0;
          end else begin
            ptr_n = ptr - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_drv_sequencer.sv
// Scoreboard bench for clk_drv_sequencer: an event-schedule reference
// model predicts outputs per cycle, a negedge monitor compares them.
module tb_clk_drv_sequencer;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int LC = 16;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_EN   = 2;
  localparam int M_RUN  = 3;
  localparam int M_DIS  = 4;

  logic          CLK;
  logic          RST_B;
  logic          start;
  logic          stop;
  logic          pll_lock;
  logic [N-1:0]  chan_mask;
  logic [SW-1:0] stagger;
  logic [N-1:0]  drv_en;
  logic          busy;
  logic          ready;
  logic          lock_err;

  clk_drv_sequencer #(
    .N_DRV(N), .STAGGER_W(SW), .LOCK_CYC(LC)
  ) dut (
    .CLK(CLK), .RST_B(RST_B),
    .start(start), .stop(stop),
    .pll_lock(pll_lock),
    .chan_mask(chan_mask), .stagger(stagger),
    .drv_en(drv_en), .busy(busy),
    .ready(ready), .lock_err(lock_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int idx;
    bit val;
  } ev_t;

  ev_t          sched[$];
  logic [N+2:0] expq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mode = M_IDLE;
  int           lock_run = 0;
  int           end_cyc = 0;
  logic [N-1:0] cap_mask = '0;
  int           cap_stag = 0;
  logic [N-1:0] exp_en = '0;
  bit           exp_err = 0;
  logic [N-1:0] mask_in = '0;
  logic [SW-1:0] stag_in = '0;

  // Timeline of enable/disable events in absolute cycles.
  task automatic build(input bit up);
    int t;
    t = cyc + 1;
    sched.delete();
    for (int k = 0; k < N; k++) begin
      int i;
      i = up ? k : N - 1 - k;
      if (cap_mask[i]) sched.push_back('{t, i, up});
      end_cyc = t;
      t += cap_mask[i] ? cap_stag + 1 : 1;
    end
  endtask

  task automatic lock_loss();
    exp_en  = '0;
    exp_err = 1;
    mode    = M_IDLE;
    sched.delete();
  endtask

  task automatic model(input bit st, sp, lk, rn);
    ev_t e;
    cyc++;
    if (!rn) begin
      mode = M_IDLE; exp_en = '0; exp_err = 0;
      lock_run = 0; sched.delete();
    end else begin
      case (mode)
        M_IDLE: if (st && !sp) begin
          mode = M_WAIT; exp_err = 0; lock_run = 0;
          cap_mask = mask_in; cap_stag = int'(stag_in);
        end
        M_WAIT: begin
          if (sp) mode = M_IDLE;
          else if (!lk) lock_run = 0;
          else begin
            lock_run++;
            if (lock_run == LC) begin
              mode = M_EN; build(1);
            end
          end
        end
        M_EN: begin
          if (!lk) lock_loss();
          else if (sp) begin
            mode = M_DIS; build(0);
          end else begin
            while (sched.size() > 0 && sched[0].cyc == cyc) begin
              e = sched.pop_front();
              exp_en[e.idx] = e.val;
            end
            if (cyc == end_cyc) mode = M_RUN;
          end
        end
        M_RUN: begin
          if (!lk) lock_loss();
          else if (sp) begin
            mode = M_DIS; build(0);
          end
        end
        default: begin
          while (sched.size() > 0 && sched[0].cyc == cyc) begin
            e = sched.pop_front();
            exp_en[e.idx] = e.val;
          end
          if (cyc == end_cyc) begin
            mode = M_IDLE; exp_en = '0;
          end
        end
      endcase
    end
    expq.push_back({exp_en,
                    1'(mode == M_WAIT || mode == M_EN || mode == M_DIS),
                    1'(mode == M_RUN), exp_err});
  endtask

  task automatic step(input bit st, sp, lk, input bit rn = 1);
    @(negedge CLK);
    RST_B = rn; start = st; stop = sp; pll_lock = lk;
    chan_mask = mask_in; stagger = stag_in;
    @(posedge CLK);
    model(st, sp, lk, rn);
  endtask

  always @(negedge CLK) begin
    logic [N+2:0] ex;
    logic [N+2:0] ac;
    if (expq.size() != 0) begin
      ex = expq.pop_front();
      ac = {drv_en, busy, ready, lock_err};
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL outputs cyc=%0d: got en=%b busy=%b rdy=%b err=%b, want en=%b busy=%b rdy=%b err=%b",
                 cyc, ac[N+2:3], ac[2], ac[1], ac[0],
                 ex[N+2:3], ex[2], ex[1], ex[0]);
      end
    end
  end

  task automatic run_idle(input int n, input bit lk = 1);
    repeat (n) step(0, 0, lk);
  endtask

  task automatic begin_seq(input logic [N-1:0] m, input logic [SW-1:0] s);
    mask_in = m; stag_in = s;
    step(1, 0, 1);
  endtask

  initial begin
    RST_B = 0; start = 0; stop = 0; pll_lock = 0;
    chan_mask = '0; stagger = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    run_idle(3);

    // basic power-up, then stop in RUN
    begin_seq(4'b1111, 8'd2);
    run_idle(35);
    step(0, 1, 1);
    run_idle(15);

    // sparse mask with a lock glitch in WAIT_LOCK
    begin_seq(4'b1010, 8'd0);
    run_idle(5);
    step(0, 0, 0);
    run_idle(25);

    // orderly power-down, 4-cycle spacing
    begin_seq(4'b1111, 8'd3);
    run_idle(35);
    step(0, 1, 1);
    run_idle(20);

    // lock loss in RUN, then start clears lock_err
    begin_seq(4'b1111, 8'd1);
    run_idle(28);
    step(0, 0, 0);
    run_idle(3);
    begin_seq(4'b0110, 8'd1);
    run_idle(4);
    step(0, 1, 1);
    run_idle(3);

    // start+stop in IDLE; start and mask change during ENABLE
    mask_in = 4'b1111;
    step(1, 1, 1);
    run_idle(3);
    begin_seq(4'b1101, 8'd2);
    run_idle(18);
    mask_in = 4'b0010; stag_in = 8'd7;
    step(1, 0, 1);
    run_idle(20);
    step(1, 1, 1);
    run_idle(20);

    // async reset mid-ENABLE with two bits set
    begin_seq(4'b1111, 8'd0);
    for (int i = 0; i < 40; i++) begin
      if (mode == M_EN && $countones(exp_en) == 2) break;
      step(0, 0, 1);
    end
    @(negedge CLK);
    #1 RST_B = 0;
    #1;
    checks++;
    if ({drv_en, busy, ready, lock_err} !== '0) begin
      errors++;
      $display("FAIL async_rst: got en=%b busy=%b rdy=%b err=%b, want all 0",
               drv_en, busy, ready, lock_err);
    end
    step(0, 0, 1, 0);
    run_idle(3);

    // empty mask: ENABLE passes in N cycles
    begin_seq(4'b0000, 8'd5);
    run_idle(24);
    step(0, 1, 1);
    run_idle(6);

    // largest gap
    begin_seq(4'b1001, 8'hFF);
    run_idle(LC + 300);
    step(0, 1, 1);
    run_idle(270);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      mask_in = N'($urandom);
      stag_in = SW'($urandom_range(0, 5));
      step(($urandom % 20) == 0, ($urandom % 40) == 0,
           ($urandom % 60) != 0, ($urandom % 1500) != 0);
    end

    @(negedge CLK);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
